// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared sizing, types and helpers for the memory-port arbiter.
package mem_arb_pkg;
   localparam int unsigned DefNumReq   = 3;
   localparam int unsigned DefTidWidth = 2;
   localparam int unsigned DefNumTid   = 2 ** DefTidWidth;
   typedef logic [DefTidWidth-1:0]       tid_t;
   typedef logic [$clog2(DefNumReq)-1:0] owner_t;
   function automatic int unsigned num_tid(input int unsigned tw);
      return 32'd1 << tw;
   endfunction
endpackage

// File: rtl/rr_arb_tree_lite.sv
// rr_arb_tree_lite: combinational round-robin pick, first request at or after ptr_i wins.
module rr_arb_tree_lite #(
   parameter int unsigned N = 3,
   localparam int unsigned IdxW = N > 1 ? $clog2(N) : 1
)(
   input  logic [N-1:0]    req_i,
   input  logic [IdxW-1:0] ptr_i,
   output logic [N-1:0]    gnt_o,
   output logic [IdxW-1:0] idx_o,
   output logic            valid_o
);
   int j;
   logic [IdxW-1:0] sel;
   always_comb begin
      gnt_o   = '0;
      idx_o   = '0;
      valid_o = 1'b0;
      j       = 0;
      sel     = '0;
      for (int k = 0; k < int'(N); k++) begin
         j   = (int'(ptr_i) + k) % int'(N);
         sel = IdxW'(j);
         if (!valid_o && req_i[sel]) begin
            gnt_o[sel] = 1'b1;
            idx_o      = sel;
            valid_o    = 1'b1;
         end
      end
   end
endmodule

// File: rtl/mem_tid_arbiter.sv
// mem_tid_arbiter: round-robin grant of requesters onto one memory port with
// transaction-ID allocation, ID-routed responses and non-idempotent serialization.
module mem_tid_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned NumReq   = DefNumReq,
   parameter int unsigned TidWidth = DefTidWidth,
   parameter int unsigned ReqWidth = 64,
   parameter int unsigned RspWidth = 64
)(
   input  logic                               clk_i,
   input  logic                               rst_ni,
   input  logic [NumReq-1:0]                  req_valid_i,
   input  logic [NumReq-1:0]                  req_nc_i,
   input  logic [NumReq-1:0][ReqWidth-1:0]    req_data_i,
   output logic [NumReq-1:0]                  req_ready_o,
   output logic                               mem_valid_o,
   input  logic                               mem_ready_i,
   output logic [TidWidth-1:0]                mem_tid_o,
   output logic [ReqWidth-1:0]                mem_data_o,
   input  logic                               rsp_valid_i,
   input  logic [TidWidth-1:0]                rsp_tid_i,
   input  logic [RspWidth-1:0]                rsp_data_i,
   output logic [NumReq-1:0]                  rsp_valid_o,
   output logic [RspWidth-1:0]                rsp_data_o,
   output logic [TidWidth:0]                  outstanding_o,
   output logic                               err_o
);
   localparam int unsigned NumTid = num_tid(TidWidth);
   localparam int unsigned OwnW   = NumReq > 1 ? $clog2(NumReq) : 1;
   localparam int unsigned CntW   = TidWidth + 1;
   localparam logic [NumReq-1:0] OneHot0 = NumReq'(1);

   logic [NumTid-1:0]            tid_busy_q, tid_busy_d;
   logic [NumTid-1:0][OwnW-1:0]  owner_q, owner_d;
   logic                         nc_pend_q, nc_pend_d;
   logic [OwnW-1:0]              rr_ptr_q, rr_ptr_d;
   logic                         mem_valid_q, mem_valid_d;
   logic [TidWidth-1:0]          mem_tid_q, mem_tid_d;
   logic [ReqWidth-1:0]          mem_data_q, mem_data_d;
   logic [NumReq-1:0]            rsp_valid_q, rsp_valid_d;
   logic [RspWidth-1:0]          rsp_data_q, rsp_data_d;
   logic                         err_q, err_d;

   logic [CntW-1:0]   outstanding;
   logic              out_free, base_ok, nc_ok, any_free, win_valid, rsp_hit;
   logic [NumReq-1:0] elig, gnt;
   logic [OwnW-1:0]   win_idx;
   logic [NumTid-1:0] free_gnt;
   logic [TidWidth-1:0] free_idx;

   always_comb begin
      outstanding = '0;
      for (int k = 0; k < int'(NumTid); k++) outstanding = outstanding + CntW'(tid_busy_q[k]);
   end

   assign out_free = !mem_valid_q || mem_ready_i;
   // Gated by rst_ni so no grant is visible while reset is held.
   assign base_ok  = rst_ni && out_free && any_free && !nc_pend_q;
   assign nc_ok    = (outstanding == '0) && !mem_valid_q;
   assign elig     = req_valid_i & {NumReq{base_ok}} & (~req_nc_i | {NumReq{nc_ok}});
   assign rsp_hit  = rsp_valid_i && tid_busy_q[rsp_tid_i];

   rr_arb_tree_lite #(.N(NumReq)) u_req_arb (
      .req_i   (elig),
      .ptr_i   (rr_ptr_q),
      .gnt_o   (gnt),
      .idx_o   (win_idx),
      .valid_o (win_valid)
   );

   // Pointer tied to 0 turns the round-robin pick into a lowest-free-ID search.
   rr_arb_tree_lite #(.N(NumTid)) u_tid_pick (
      .req_i   (~tid_busy_q),
      .ptr_i   ('0),
      .gnt_o   (free_gnt),
      .idx_o   (free_idx),
      .valid_o (any_free)
   );

   always_comb begin
      tid_busy_d = tid_busy_q;
      owner_d    = owner_q;
      if (rsp_hit) tid_busy_d[rsp_tid_i] = 1'b0;
      if (win_valid) begin
         tid_busy_d        = tid_busy_d | free_gnt;
         owner_d[free_idx] = win_idx;
      end
      nc_pend_d   = (nc_pend_q && !rsp_hit) || (win_valid && req_nc_i[win_idx]);
      rr_ptr_d    = !win_valid ? rr_ptr_q : (win_idx == OwnW'(NumReq - 1)) ? '0 : win_idx + 1'b1;
      mem_valid_d = win_valid || (mem_valid_q && !mem_ready_i);
      mem_tid_d   = win_valid ? free_idx : mem_tid_q;
      mem_data_d  = win_valid ? req_data_i[win_idx] : mem_data_q;
      rsp_valid_d = rsp_hit ? OneHot0 << owner_q[rsp_tid_i] : '0;
      rsp_data_d  = rsp_hit ? rsp_data_i : rsp_data_q;
      err_d       = err_q || (rsp_valid_i && !tid_busy_q[rsp_tid_i]);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         tid_busy_q  <= '0;
         owner_q     <= '0;
         nc_pend_q   <= 1'b0;
         rr_ptr_q    <= '0;
         mem_valid_q <= 1'b0;
         mem_tid_q   <= '0;
         mem_data_q  <= '0;
         rsp_valid_q <= '0;
         rsp_data_q  <= '0;
         err_q       <= 1'b0;
      end else begin
         tid_busy_q  <= tid_busy_d;
         owner_q     <= owner_d;
         nc_pend_q   <= nc_pend_d;
         rr_ptr_q    <= rr_ptr_d;
         mem_valid_q <= mem_valid_d;
         mem_tid_q   <= mem_tid_d;
         mem_data_q  <= mem_data_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
         err_q       <= err_d;
      end
   end

   assign req_ready_o   = gnt;
   assign mem_valid_o   = mem_valid_q;
   assign mem_tid_o     = mem_tid_q;
   assign mem_data_o    = mem_data_q;
   assign rsp_valid_o   = rsp_valid_q;
   assign rsp_data_o    = rsp_data_q;
   assign outstanding_o = outstanding;
   assign err_o         = err_q;
endmodule

// File: tb/tb_mem_tid_arbiter.sv
// tb_mem_tid_arbiter: table-driven per-cycle vectors with a scoreboard for the memory-side payloads.
module tb_mem_tid_arbiter;
   logic clk_i = 1'b0;
   logic rst_ni = 1'b0;
   always #5 clk_i = ~clk_i;

   logic [2:0]       req_valid_i = '0, req_nc_i = '0, req_ready_o, rsp_valid_o;
   logic [2:0][63:0] req_data_i = '0;
   logic             mem_valid_o, mem_ready_i = 1'b0, rsp_valid_i = 1'b0, err_o;
   logic [1:0]       mem_tid_o, rsp_tid_i = '0;
   logic [63:0]      mem_data_o, rsp_data_i = '0, rsp_data_o;
   logic [2:0]       outstanding_o;

   mem_tid_arbiter dut (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .req_valid_i(req_valid_i), .req_nc_i(req_nc_i), .req_data_i(req_data_i), .req_ready_o(req_ready_o),
      .mem_valid_o(mem_valid_o), .mem_ready_i(mem_ready_i), .mem_tid_o(mem_tid_o), .mem_data_o(mem_data_o),
      .rsp_valid_i(rsp_valid_i), .rsp_tid_i(rsp_tid_i), .rsp_data_i(rsp_data_i),
      .rsp_valid_o(rsp_valid_o), .rsp_data_o(rsp_data_o), .outstanding_o(outstanding_o), .err_o(err_o)
   );

   typedef struct {
      logic [2:0] v, nc;
      logic       mr, rv;
      logic [1:0] rt;
      logic [2:0] rdy;
      logic [1:0] tid;
      logic [2:0] rspv, outst;
      logic       err;
   } vec_t;
   typedef struct {
      logic [1:0]  tid;
      logic [63:0] data;
   } exp_t;

   vec_t tbl[$];
   exp_t sb[$];
   int checks = 0;
   int failures = 0;

   function automatic logic [63:0] payload(input int r, input int i);
      return {32'hC0DE0000 + 32'(i), 32'(r)};
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic add(input logic [2:0] v, input logic [2:0] nc, input logic mr, input logic rv,
                      input logic [1:0] rt, input logic [2:0] rdy, input logic [1:0] tid,
                      input logic [2:0] rspv, input logic [2:0] outst, input logic err);
      vec_t e;
      e.v = v; e.nc = nc; e.mr = mr; e.rv = rv; e.rt = rt;
      e.rdy = rdy; e.tid = tid; e.rspv = rspv; e.outst = outst; e.err = err;
      tbl.push_back(e);
   endtask

   task automatic chk_zero(input string nm);
      chk({nm, "_ready"}, 64'(req_ready_o), 64'd0);
      chk({nm, "_mvalid"}, 64'(mem_valid_o), 64'd0);
      chk({nm, "_mtid"}, 64'(mem_tid_o), 64'd0);
      chk({nm, "_mdata"}, mem_data_o, 64'd0);
      chk({nm, "_rvalid"}, 64'(rsp_valid_o), 64'd0);
      chk({nm, "_rdata"}, rsp_data_o, 64'd0);
      chk({nm, "_outst"}, 64'(outstanding_o), 64'd0);
      chk({nm, "_err"}, 64'(err_o), 64'd0);
   endtask

   task automatic do_reset();
      rst_ni = 1'b0;
      req_valid_i = '0; req_nc_i = '0; mem_ready_i = 1'b0; rsp_valid_i = 1'b0; rsp_tid_i = '0;
      #1;
      chk_zero("reset");
      repeat (2) @(posedge clk_i);
      #1 rst_ni = 1'b1;
      sb.delete();
   endtask

   task automatic run_rows(input int lo, input int hi);
      exp_t e;
      for (int r = lo; r <= hi; r++) begin
         @(posedge clk_i);
         #1;
         req_valid_i = tbl[r].v;
         req_nc_i    = tbl[r].nc;
         mem_ready_i = tbl[r].mr;
         rsp_valid_i = tbl[r].rv;
         rsp_tid_i   = tbl[r].rt;
         rsp_data_i  = {32'hBEEF0000, 32'(r)};
         for (int i = 0; i < 3; i++) req_data_i[i] = payload(r, i);
         #3;
         chk($sformatf("ready_row%0d", r), 64'(req_ready_o), 64'(tbl[r].rdy));
         chk($sformatf("outst_row%0d", r), 64'(outstanding_o), 64'(tbl[r].outst));
         chk($sformatf("err_row%0d", r), 64'(err_o), 64'(tbl[r].err));
         chk($sformatf("rspv_row%0d", r), 64'(rsp_valid_o), 64'(tbl[r].rspv));
         if (tbl[r].rspv != 3'b000)
            chk($sformatf("rspdata_row%0d", r), rsp_data_o, {32'hBEEF0000, 32'(r - 1)});
         chk($sformatf("mvalid_row%0d", r), 64'(mem_valid_o), 64'(sb.size() != 0));
         if (mem_valid_o && sb.size() != 0) begin
            chk($sformatf("mtid_row%0d", r), 64'(mem_tid_o), 64'(sb[0].tid));
            chk($sformatf("mdata_row%0d", r), mem_data_o, sb[0].data);
            if (mem_ready_i) void'(sb.pop_front());
         end
         if (tbl[r].rdy != 3'b000) begin
            e.tid = tbl[r].tid;
            e.data = '0;
            for (int i = 0; i < 3; i++) if (tbl[r].rdy[i]) e.data = payload(r, i);
            sb.push_back(e);
         end
      end
   endtask

   int a0, b0, c0;

   initial begin
      // v, nc, mem_ready, rsp_valid, rsp_tid | ready, tid, rsp_valid_o, outstanding, err
      a0 = tbl.size();
      add(3'b010, 3'b000, 1, 0, 0, 3'b010, 0, 3'b000, 0, 0);
      add(3'b000, 3'b000, 1, 0, 0, 3'b000, 0, 3'b000, 1, 0);
      b0 = tbl.size();
      add(3'b111, 3'b000, 1, 0, 0, 3'b001, 0, 3'b000, 0, 0);
      add(3'b111, 3'b000, 1, 0, 0, 3'b010, 1, 3'b000, 1, 0);
      add(3'b111, 3'b000, 1, 0, 0, 3'b100, 2, 3'b000, 2, 0);
      add(3'b111, 3'b000, 1, 0, 0, 3'b001, 3, 3'b000, 3, 0);
      add(3'b111, 3'b000, 1, 0, 0, 3'b000, 0, 3'b000, 4, 0);
      add(3'b111, 3'b000, 1, 1, 2, 3'b000, 0, 3'b000, 4, 0);
      add(3'b111, 3'b000, 1, 0, 0, 3'b010, 2, 3'b100, 3, 0);
      add(3'b000, 3'b000, 1, 0, 0, 3'b000, 0, 3'b000, 4, 0);
      add(3'b000, 3'b000, 1, 1, 0, 3'b000, 0, 3'b000, 4, 0);
      add(3'b000, 3'b000, 1, 1, 1, 3'b000, 0, 3'b001, 3, 0);
      add(3'b000, 3'b000, 1, 1, 2, 3'b000, 0, 3'b010, 2, 0);
      add(3'b000, 3'b000, 1, 1, 3, 3'b000, 0, 3'b010, 1, 0);
      add(3'b000, 3'b000, 1, 1, 3, 3'b000, 0, 3'b001, 0, 0);
      add(3'b000, 3'b000, 1, 0, 0, 3'b000, 0, 3'b000, 0, 1);
      add(3'b011, 3'b000, 1, 0, 0, 3'b001, 0, 3'b000, 0, 1);
      add(3'b011, 3'b000, 1, 0, 0, 3'b010, 1, 3'b000, 1, 1);
      add(3'b111, 3'b100, 1, 0, 0, 3'b001, 2, 3'b000, 2, 1);
      add(3'b111, 3'b100, 1, 0, 0, 3'b010, 3, 3'b000, 3, 1);
      add(3'b100, 3'b100, 1, 1, 0, 3'b000, 0, 3'b000, 4, 1);
      add(3'b100, 3'b100, 1, 1, 1, 3'b000, 0, 3'b001, 3, 1);
      add(3'b100, 3'b100, 1, 1, 2, 3'b000, 0, 3'b010, 2, 1);
      add(3'b100, 3'b100, 1, 1, 3, 3'b000, 0, 3'b001, 1, 1);
      add(3'b100, 3'b100, 1, 0, 0, 3'b100, 0, 3'b010, 0, 1);
      add(3'b111, 3'b100, 1, 0, 0, 3'b000, 0, 3'b000, 1, 1);
      add(3'b011, 3'b000, 1, 0, 0, 3'b000, 0, 3'b000, 1, 1);
      add(3'b011, 3'b000, 1, 1, 0, 3'b000, 0, 3'b000, 1, 1);
      add(3'b011, 3'b000, 1, 0, 0, 3'b001, 0, 3'b100, 0, 1);
      add(3'b000, 3'b000, 1, 0, 0, 3'b000, 0, 3'b000, 1, 1);
      add(3'b111, 3'b000, 0, 0, 0, 3'b010, 1, 3'b000, 1, 1);
      for (int i = 0; i < 4; i++) add(3'b111, 3'b000, 0, 0, 0, 3'b000, 0, 3'b000, 2, 1);
      c0 = tbl.size();
      add(3'b111, 3'b000, 1, 0, 0, 3'b001, 0, 3'b000, 0, 0);
      add(3'b000, 3'b000, 1, 0, 0, 3'b000, 0, 3'b000, 1, 0);

      do_reset();
      run_rows(a0, b0 - 1);
      do_reset();
      run_rows(b0, c0 - 1);
      // Asynchronous reset in the middle of the stall, away from any clock edge.
      rst_ni = 1'b0;
      #1;
      chk_zero("midstall_reset");
      do_reset();
      run_rows(c0, tbl.size() - 1);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
